dmem_bridge: RTL and testbench
==============================

DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter ADDR_WITDH, default 32, byte-address width.
REQ-002 Parameter DATA_WITDH, default 32, data word width.
REQ-003 Parameter TIMEOUT, default 255, maximum response-wait cycles (1..255).
REQ-004 Port clk input 1, single clock; all state SHALL update on its rising edge.
REQ-005 Port rst input 1, asynchronous, active-low reset.
REQ-006 Port alu_resultm input ADDR_WITDH, MEM-stage byte address.
REQ-007 Port rd2_turem input DATA_WITDH, store data, already lane-aligned.
REQ-008 Port wmask input 4, store byte strobes.
REQ-009 Port mem_wem input 1, store request.
REQ-010 Port mem_rem input 1, load request.
REQ-011 Port data output DATA_WITDH, load word returned to the CPU.
REQ-012 Port stall output 1, freezes the CPU pipeline while an access is pending.
REQ-013 Port err output 1, sticky bus-error or timeout flag.
REQ-014 Port bus_valid output 1, request valid.
REQ-015 Port bus_ready input 1, request accepted.
REQ-016 Port bus_addr output ADDR_WITDH, word-aligned address.
REQ-017 Port bus_wdata output DATA_WITDH, write data.
REQ-018 Port bus_wstrb output 4, byte strobes, 0000 on loads.
REQ-019 Port bus_we output 1, 1 means write.
REQ-020 Port bus_rsp_valid input 1, response valid.
REQ-021 Port bus_rdata input DATA_WITDH, response data.
REQ-022 Port bus_rsp_err input 1, response error.

Function
REQ-023 FSM states: IDLE, REQ, RSP, DONE.
REQ-024 IDLE with mem_wem|mem_rem=1: capture the address with bits [1:0] forced to 0, plus wdata, wmask, and we=mem_wem; go to REQ; stall=1 combinationally in that same cycle.
REQ-025 If mem_wem and mem_rem are both 1, the access is a store.
REQ-026 REQ: bus_valid=1 with the captured fields held stable until bus_valid&bus_ready; then go to RSP.
REQ-027 RSP: on bus_rsp_valid, register bus_rdata (0 for stores) into data, set err if bus_rsp_err, and go to DONE.
REQ-028 RSP: an 8-bit wait counter clears on RSP entry and increments each cycle without a response. When the count equals TIMEOUT: go to DONE, set data=0, set err.
REQ-029 DONE: stall=0 for exactly one cycle, with data valid; go unconditionally to IDLE. Request inputs in DONE are never captured, so no duplicate issue occurs.
REQ-030 stall = (IDLE & request) | REQ | RSP; stall=0 in DONE and in idle IDLE.
REQ-031 bus_rsp_valid outside RSP SHALL be ignored.
REQ-032 bus_valid SHALL be 0 in every state except REQ.
REQ-033 Minimum access latency: capture cycle, then 1 REQ cycle, 1 RSP cycle, DONE; stall is high for 3 cycles.
REQ-034 data SHALL hold its last value outside DONE.
REQ-035 err is sticky until reset.

Reset
REQ-036 rst=0 asynchronously forces IDLE and these outputs to 0: bus_valid, bus_we, bus_wstrb, bus_addr, bus_wdata, data, stall (combinational from IDLE), err, and the wait counter.
REQ-037 Reset mid-access abandons the transaction; a later bus_rsp_valid is ignored per REQ-031.

Structure
REQ-038 A shared package SHALL hold the FSM state enum (2 bits: IDLE=0, REQ=1, RSP=2, DONE=3), the BUS_WSTRB_W=4 constant, and the default TIMEOUT value.
REQ-039 A single sub-module, dmem_req_reg, SHALL hold the captured request fields, with load-enable and reset.
REQ-040 The block instantiates beside the cpu top: stall gates the pc and stage enables; data feeds the cpu data input.

Verification
REQ-041 Load, addr 0x0000_1006, mem_rem=1, bus_ready=1 at once, rsp after 1 cycle with rdata 0xDEADBEEF -> bus_addr=0x0000_1004, bus_wstrb=0000, bus_we=0, stall high 3 cycles, data=0xDEADBEEF in DONE, err=0.
REQ-042 Store, addr 0x20, wdata 0x0000AB00, wmask 0010, bus_ready held low 4 cycles -> bus_valid and all fields stable for 5 cycles, bus_wstrb=0010, bus_we=1, stall released only in DONE.
REQ-043 Load with no response, TIMEOUT=4 -> DONE entered 4 cycles after RSP entry, data=0, err=1, err still 1 after 2 further good accesses.
REQ-044 rst driven low while in RSP, then released, then bus_rsp_valid pulsed -> IDLE, stall=0, data unchanged at 0, no state change.
REQ-045 Load held asserted across DONE, then deasserted the next cycle -> exactly one bus handshake.
REQ-046 Load with bus_rsp_err=1 -> err=1, data=bus_rdata, stall released normally.

Source files
------------

// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the CPU data-memory bridge.
package dmem_bridge_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int BUS_WSTRB_W = 4;
  localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/dmem_req_reg.sv
// Holds the captured request fields for the duration of one bus access.
module dmem_req_reg
  import dmem_bridge_pkg::*;
#(
  parameter int ADDR_WITDH = 32,
  parameter int DATA_WITDH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [ADDR_WITDH-1:0]  cap_addr,
  input  logic [DATA_WITDH-1:0]  cap_wdata,
  input  logic [BUS_WSTRB_W-1:0] cap_wstrb,
  input  logic                   cap_we,
  output logic [ADDR_WITDH-1:0]  addr,
  output logic [DATA_WITDH-1:0]  wdata,
  output logic [BUS_WSTRB_W-1:0] wstrb,
  output logic                   we
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr  <= '0;
      wdata <= '0;
      wstrb <= '0;
      we    <= 1'b0;
    end else if (load) begin
      addr  <= cap_addr;
      wdata <= cap_wdata;
      wstrb <= cap_wstrb;
      we    <= cap_we;
    end
  end
endmodule

// File: rtl/dmem_bridge.sv
// Bridges MEM-stage load/store requests onto a valid/ready bus with a
// separate response phase, stalling the CPU until the access completes.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int ADDR_WITDH = 32,
  parameter int DATA_WITDH = 32,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WITDH-1:0]  alu_resultm,
  input  logic [DATA_WITDH-1:0]  rd2_turem,
  input  logic [BUS_WSTRB_W-1:0] wmask,
  input  logic                   mem_wem,
  input  logic                   mem_rem,
  output logic [DATA_WITDH-1:0]  data,
  output logic                   stall,
  output logic                   err,
  output logic                   bus_valid,
  input  logic                   bus_ready,
  output logic [ADDR_WITDH-1:0]  bus_addr,
  output logic [DATA_WITDH-1:0]  bus_wdata,
  output logic [BUS_WSTRB_W-1:0] bus_wstrb,
  output logic                   bus_we,
  input  logic                   bus_rsp_valid,
  input  logic [DATA_WITDH-1:0]  bus_rdata,
  input  logic                   bus_rsp_err
);
  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t     state, nxt;
  logic       cap, req, rsp_hit, tmo_hit;
  logic [7:0] wcnt;
  logic [ADDR_WITDH-1:0] addr_al;

  assign req     = mem_wem | mem_rem;
  assign rsp_hit = (state == RSP) && bus_rsp_valid;
  // Timeout fires on the cycle whose missed response brings the count to TIMEOUT.
  assign tmo_hit = (state == RSP) && !bus_rsp_valid && ((wcnt + 8'd1) == TMO);

  always_comb begin
    addr_al      = alu_resultm;
    addr_al[1:0] = 2'b00;
  end

  always_comb begin
    nxt       = state;
    cap       = 1'b0;
    stall     = 1'b0;
    bus_valid = 1'b0;
    case (state)
      IDLE: if (req) begin
        cap   = 1'b1;
        stall = 1'b1;
        nxt   = REQ;
      end
      REQ: begin
        stall     = 1'b1;
        bus_valid = 1'b1;
        if (bus_ready) nxt = RSP;
      end
      RSP: begin
        stall = 1'b1;
        if (rsp_hit || tmo_hit) nxt = DONE;
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                wcnt <= '0;
    else if ((state == RSP) && !bus_rsp_valid) wcnt <= wcnt + 8'd1;
    else                                     wcnt <= '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data <= '0;
      err  <= 1'b0;
    end else if (rsp_hit) begin
      data <= bus_we ? '0 : bus_rdata;
      if (bus_rsp_err) err <= 1'b1;
    end else if (tmo_hit) begin
      data <= '0;
      err  <= 1'b1;
    end
  end

  // Loads carry no strobes; store wins when both requests are raised.
  dmem_req_reg #(
    .ADDR_WITDH(ADDR_WITDH),
    .DATA_WITDH(DATA_WITDH)
  ) u_req_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (cap),
    .cap_addr  (addr_al),
    .cap_wdata (rd2_turem),
    .cap_wstrb (mem_wem ? wmask : '0),
    .cap_we    (mem_wem),
    .addr      (bus_addr),
    .wdata     (bus_wdata),
    .wstrb     (bus_wstrb),
    .we        (bus_we)
  );
endmodule

// File: tb/tb_dmem_bridge.sv
// Directed and randomized accesses against a transaction-level model of the bridge.
module tb_dmem_bridge;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_resultm, rd2_turem, data, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  wmask, bus_wstrb;
  logic        mem_wem, mem_rem, stall, err, bus_valid, bus_ready, bus_we;
  logic        bus_rsp_valid, bus_rsp_err;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] model_data;
  logic        model_err;

  always #5 clk = ~clk;

  dmem_bridge #(.ADDR_WITDH(32), .DATA_WITDH(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .alu_resultm(alu_resultm), .rd2_turem(rd2_turem),
    .wmask(wmask), .mem_wem(mem_wem), .mem_rem(mem_rem), .data(data),
    .stall(stall), .err(err), .bus_valid(bus_valid), .bus_ready(bus_ready),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_we(bus_we), .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata),
    .bus_rsp_err(bus_rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access; the bench plays the bus slave. rsp_dly<0 means no response.
  task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m,
                        input logic w, input logic r, input int rdy_dly, input int rsp_dly,
                        input logic [31:0] rd, input logic rerr, input bit hold_done);
    bit          to, done;
    int          stall_cyc, vld_cyc, hs, rsp_cnt;
    logic [31:0] exp_data;
    logic        exp_err;
    to        = (rsp_dly < 0) || (rsp_dly >= TMO);
    exp_data  = to ? 32'h0 : (w ? 32'h0 : rd);
    exp_err   = model_err | to | (!to & rerr);
    done      = 0;
    stall_cyc = 0; vld_cyc = 0; hs = 0; rsp_cnt = 0;
    @(negedge clk);
    alu_resultm = a; rd2_turem = wd; wmask = m; mem_wem = w; mem_rem = r;
    bus_ready = 1'b0; bus_rsp_valid = 1'b0;
    #1;
    chk("cap_stall", {31'b0, stall}, 32'd1);
    chk("cap_valid", {31'b0, bus_valid}, 32'd0);
    stall_cyc = 1;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      bus_ready = 1'b0; bus_rsp_valid = 1'b0;
      bus_rdata = $urandom; bus_rsp_err = 1'($urandom_range(0, 1));
      #1;
      if (!stall) begin
        done = 1;
        chk("done_valid", {31'b0, bus_valid}, 32'd0);
        chk("done_data", data, exp_data);
        chk("done_err", {31'b0, err}, {31'b0, exp_err});
        if (!hold_done) begin mem_wem = 1'b0; mem_rem = 1'b0; end
      end else begin
        stall_cyc++;
        chk("data_hold", data, model_data);
        if (bus_valid) begin
          vld_cyc++;
          chk("bus_addr", bus_addr, a & 32'hFFFF_FFFC);
          chk("bus_wdata", bus_wdata, wd);
          chk("bus_wstrb", {28'b0, bus_wstrb}, {28'b0, (w ? m : 4'b0000)});
          chk("bus_we", {31'b0, bus_we}, {31'b0, w});
          // stray response during the request phase must be ignored
          bus_rsp_valid = 1'($urandom_range(0, 1));
          bus_rsp_err   = 1'b1;
          if (vld_cyc == rdy_dly + 1) begin bus_ready = 1'b1; hs++; end
        end else if (hs > 0) begin
          if (!to && rsp_cnt == rsp_dly) begin
            bus_rsp_valid = 1'b1; bus_rdata = rd; bus_rsp_err = rerr;
          end
          rsp_cnt++;
        end
      end
    end
    if (!done) chk("done_bound", 32'd0, 32'd1);
    chk("stall_cycles", stall_cyc, 1 + (rdy_dly + 1) + (to ? TMO : rsp_dly + 1));
    chk("valid_cycles", vld_cyc, rdy_dly + 1);
    chk("handshakes", hs, 1);
    if (hold_done) begin
      @(negedge clk);
      mem_wem = 1'b0; mem_rem = 1'b0;
      #1;
      chk("post_idle_stall", {31'b0, stall}, 32'd0);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk); #1;
        chk("post_idle_valid", {31'b0, bus_valid}, 32'd0);
        chk("post_idle_stall2", {31'b0, stall}, 32'd0);
      end
    end
    model_data = exp_data;
    model_err  = exp_err;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_stall"}, {31'b0, stall}, 32'd0);
    chk({tag, "_valid"}, {31'b0, bus_valid}, 32'd0);
    chk({tag, "_we"}, {31'b0, bus_we}, 32'd0);
    chk({tag, "_wstrb"}, {28'b0, bus_wstrb}, 32'd0);
    chk({tag, "_addr"}, bus_addr, 32'd0);
    chk({tag, "_wdata"}, bus_wdata, 32'd0);
    chk({tag, "_data"}, data, 32'd0);
    chk({tag, "_err"}, {31'b0, err}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rw, rr;
    logic        sw, sr;
    rst = 1'b0;
    alu_resultm = '0; rd2_turem = '0; wmask = '0; mem_wem = 1'b0; mem_rem = 1'b0;
    bus_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = '0; bus_rsp_err = 1'b0;
    model_data = '0; model_err = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) rst = 1'b1;

    // aligned-down load, immediate ready, one-cycle response
    access(32'h0000_1006, 32'h0, 4'b0000, 1'b0, 1'b1, 0, 0, 32'hDEAD_BEEF, 1'b0, 0);
    // store with ready low 4 cycles
    access(32'h0000_0020, 32'h0000_AB00, 4'b0010, 1'b1, 1'b0, 4, 0, 32'h1234_5678, 1'b0, 0);
    // load held across DONE
    access(32'h0000_0104, 32'h0, 4'b0000, 1'b0, 1'b1, 1, 1, 32'hCAFE_F00D, 1'b0, 1);
    // both requests high is a store
    access(32'h0000_0043, 32'h5555_AAAA, 4'b1111, 1'b1, 1'b1, 0, 2, 32'h7777_7777, 1'b0, 0);

    for (int i = 0; i < 12; i++) begin
      ra = $urandom; rw = $urandom; rr = $urandom;
      sw = 1'($urandom_range(0, 1));
      sr = sw ? 1'($urandom_range(0, 1)) : 1'b1;
      access(ra, rw, 4'($urandom_range(0, 15)), sw, sr,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rr, 1'b0, 0);
    end

    // bus error response on a load
    access(32'h0000_0200, 32'h0, 4'b0000, 1'b0, 1'b1, 0, 1, 32'hBAD0_0BAD, 1'b1, 0);

    @(negedge clk) rst = 1'b0;
    #1 check_reset_outputs("reset2");
    model_data = '0; model_err = 1'b0;
    @(negedge clk) rst = 1'b1;

    // timeout then two good accesses, err must stay set
    access(32'h0000_0300, 32'h0, 4'b0000, 1'b0, 1'b1, 0, -1, 32'h0, 1'b0, 0);
    access(32'h0000_0304, 32'h0, 4'b0000, 1'b0, 1'b1, 0, 0, 32'h0101_0101, 1'b0, 0);
    access(32'h0000_0308, 32'h0F0F_0F0F, 4'b1100, 1'b1, 1'b0, 1, 0, 32'h0, 1'b0, 0);

    // reset while waiting for the response, then a late response pulse
    @(negedge clk);
    alu_resultm = 32'h0000_0400; mem_rem = 1'b1; mem_wem = 1'b0; bus_ready = 1'b1;
    @(negedge clk);
    #1 chk("rrsp_req_valid", {31'b0, bus_valid}, 32'd1);
    @(negedge clk);
    bus_ready = 1'b0;
    #1 chk("rrsp_in_rsp_stall", {31'b0, stall}, 32'd1);
    #1 rst = 1'b0; mem_rem = 1'b0;
    #1 check_reset_outputs("rrsp_reset");
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    bus_rsp_valid = 1'b1; bus_rdata = 32'h9999_9999; bus_rsp_err = 1'b1;
    @(negedge clk);
    bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
    #1 check_reset_outputs("rrsp_late");
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("rrsp_settle");
    model_data = '0; model_err = 1'b0;

    // full mix: timeouts and error responses included
    for (int i = 0; i < 14; i++) begin
      ra = $urandom; rw = $urandom; rr = $urandom;
      sw = 1'($urandom_range(0, 1));
      sr = sw ? 1'($urandom_range(0, 1)) : 1'b1;
      access(ra, rw, 4'($urandom_range(0, 15)), sw, sr,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 6)) - 1, rr,
             1'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
